// File: rtl/iddmm_pkg.sv
// iddmm_pkg: shared sizes and FSM states for the Montgomery result reader
package iddmm_pkg;
   localparam int K_DEF = 256;
   localparam int N_DEF = 16;
   localparam int ADDR_W_DEF = $clog2(N_DEF);
   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/iddmm_skid_buf2.sv
// iddmm_skid_buf2: 2-entry valid/ready buffer exposing its occupancy
module iddmm_skid_buf2 #(
   parameter int K = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [K-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [K-1:0] out_data,
   output logic [1:0]   occ
);
   logic [K-1:0] head, tail;
   logic push, pop;
   assign out_valid = occ != 2'd0;
   assign out_data = head;
   assign pop = out_valid && out_ready;
   assign push = in_valid && (occ != 2'd2 || pop);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         occ <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         occ <= occ + {1'b0, push} - {1'b0, pop};
         if (pop) head <= (occ == 2'd2) ? tail : in_data;
         else if (push && occ == 2'd0) head <= in_data;
         if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) tail <= in_data;
      end
endmodule

// File: rtl/iddmm_result_rd.sv
// iddmm_result_rd: drains raw/sub result FIFOs in lockstep and streams the
// sign-selected N words LSW-first on a valid/ready interface
module iddmm_result_rd
   import iddmm_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cal_done,
   input  logic              cal_sign,
   input  logic              fifo_empty_a,
   output logic              fifo_rd_en_a,
   input  logic [K-1:0]      fifo_rd_data_a,
   input  logic              fifo_empty_sub,
   output logic              fifo_rd_en_sub,
   input  logic [K-1:0]      fifo_rd_data_sub,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [K-1:0]      res_data,
   output logic [ADDR_W-1:0] res_idx,
   output logic              res_last,
   output logic              busy,
   output logic              err_ovf
);
   localparam logic [ADDR_W:0] CNT_N = N[ADDR_W:0];
   localparam logic [ADDR_W:0] CNT_ONE = 1;
   state_t state, state_nxt;
   logic sign_cur, pending, pend_sign, rd_vld, pop, xfer;
   logic start, use_pend, start_sign, queue_evt;
   logic [ADDR_W:0] rd_cnt, out_cnt;
   logic [1:0] occ, room;
   // occupancy left after this cycle's transfer, counting the read in flight
   assign room = occ + {1'b0, rd_vld} - {1'b0, xfer};
   assign pop = state == DRAIN && !fifo_empty_a && !fifo_empty_sub && rd_cnt < CNT_N && room < 2'd2;
   assign fifo_rd_en_a = pop;
   assign fifo_rd_en_sub = pop;
   assign xfer = res_valid && res_ready;
   assign res_idx = out_cnt[ADDR_W-1:0];
   assign res_last = res_idx == CNT_N[ADDR_W-1:0] - 1'b1;
   assign busy = state != IDLE || pending;
   assign queue_evt = cal_done && !(start && !use_pend);
   always_comb begin
      state_nxt = state;
      start = 1'b0;
      use_pend = 1'b0;
      start_sign = cal_sign;
      case (state)
         IDLE: if (cal_done) begin
            state_nxt = DRAIN;
            start = 1'b1;
         end
         DRAIN: if (rd_cnt == CNT_N) state_nxt = FLUSH;
         FLUSH: if (out_cnt == CNT_N) begin
            state_nxt = (pending || cal_done) ? DRAIN : IDLE;
            start = pending || cal_done;
            use_pend = pending;
            start_sign = pending ? pend_sign : cal_sign;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         sign_cur <= 1'b0;
         pending <= 1'b0;
         pend_sign <= 1'b0;
         rd_vld <= 1'b0;
         rd_cnt <= '0;
         out_cnt <= '0;
         err_ovf <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_vld <= pop;
         if (start) begin
            sign_cur <= start_sign;
            rd_cnt <= '0;
            out_cnt <= '0;
         end else begin
            if (pop) rd_cnt <= rd_cnt + CNT_ONE;
            if (xfer) out_cnt <= out_cnt + CNT_ONE;
         end
         if (use_pend) pending <= 1'b0;
         if (queue_evt && pending) err_ovf <= 1'b1;
         if (queue_evt && !pending) begin
            pending <= 1'b1;
            pend_sign <= cal_sign;
         end
      end
   iddmm_skid_buf2 #(.K(K)) u_buf (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(rd_vld),
      .in_data(sign_cur ? fifo_rd_data_sub : fifo_rd_data_a),
      .out_valid(res_valid),
      .out_ready(res_ready),
      .out_data(res_data),
      .occ(occ)
   );
endmodule

// File: tb/tb_iddmm_result_rd.sv
// tb_iddmm_result_rd: random/directed stimulus checked against a queue model
module tb_iddmm_result_rd;
   localparam int K = 256;
   localparam int N = 16;
   localparam int AW = 4;
   logic clk = 0, rst_n = 0, cal_done = 0, cal_sign = 0, res_ready = 0;
   logic ea = 1, es = 1, starve_a = 0, starve_s = 0;
   logic fifo_empty_a, fifo_empty_sub, fifo_rd_en_a, fifo_rd_en_sub;
   logic res_valid, res_last, busy, err_ovf;
   logic [K-1:0] rd_a = '0, rd_s = '0, res_data;
   logic [AW-1:0] res_idx;
   logic [K-1:0] qa[$], qs[$], la[$], ls[$], exp_d[$];
   int exp_i[$];
   int checks = 0, fails = 0, pops = 0, xfers = 0;
   logic err_exp = 0, stall = 0;
   logic [K-1:0] pd;
   logic [AW-1:0] pi;
   assign fifo_empty_a = ea | starve_a;
   assign fifo_empty_sub = es | starve_s;
   always #5 clk = ~clk;

   iddmm_result_rd dut (
      .clk(clk), .rst_n(rst_n), .cal_done(cal_done), .cal_sign(cal_sign),
      .fifo_empty_a(fifo_empty_a), .fifo_rd_en_a(fifo_rd_en_a), .fifo_rd_data_a(rd_a),
      .fifo_empty_sub(fifo_empty_sub), .fifo_rd_en_sub(fifo_rd_en_sub), .fifo_rd_data_sub(rd_s),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
      .res_last(res_last), .busy(busy), .err_ovf(err_ovf)
   );

   task automatic chk(input bit ok, input string nm, input logic [K-1:0] act, input logic [K-1:0] req);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [K-1:0] rnd();
      logic [K-1:0] r = '0;
      for (int i = 0; i < K / 32; i++) r = {r[K-33:0], 32'($urandom)};
      return r;
   endfunction

   // FIFO pair behaviour: data appears one cycle after a pop
   always @(posedge clk) begin
      if (fifo_rd_en_a && qa.size() > 0) rd_a <= qa.pop_front();
      if (fifo_rd_en_sub && qs.size() > 0) rd_s <= qs.pop_front();
      if (fifo_rd_en_a) pops++;
      ea <= qa.size() == 0;
      es <= qs.size() == 0;
   end

   always @(negedge clk) if (rst_n) begin
      chk(fifo_rd_en_a == fifo_rd_en_sub, "pop_pair", fifo_rd_en_a, fifo_rd_en_sub);
      if (fifo_rd_en_a || fifo_rd_en_sub)
         chk(!fifo_empty_a && !fifo_empty_sub, "pop_when_empty", {fifo_empty_a, fifo_empty_sub}, 0);
      chk(pops - xfers <= 2, "outstanding", pops - xfers, 2);
      chk(err_ovf == err_exp, "err_ovf", err_ovf, err_exp);
      if (stall) begin
         chk(res_valid, "stall_valid", res_valid, 1);
         chk(res_data == pd, "stall_data", res_data, pd);
         chk(res_idx == pi, "stall_idx", res_idx, pi);
      end
      if (res_valid && res_ready) begin
         if (exp_d.size() == 0) chk(0, "spurious_word", res_data, 0);
         else begin
            chk(res_data == exp_d[0], "data", res_data, exp_d[0]);
            chk(int'(res_idx) == exp_i[0], "idx", res_idx, exp_i[0]);
            chk(res_last == (exp_i[0] == N - 1), "last", res_last, exp_i[0] == N - 1);
            void'(exp_d.pop_front());
            void'(exp_i.pop_front());
         end
         xfers++;
      end
      stall = res_valid && !res_ready;
      pd = res_data;
      pi = res_idx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [K-1:0] a, input logic [K-1:0] s);
      qa.push_back(a);
      qs.push_back(s);
      la.push_back(a);
      ls.push_back(s);
      ea = 0;
      es = 0;
   endtask

   task automatic pulse(input logic sg);
      cal_done = 1;
      cal_sign = sg;
      tick();
      cal_done = 0;
   endtask

   // accepted op: the next N loaded pairs yield the sign-selected words
   task automatic start_op(input logic sg);
      for (int i = 0; i < N; i++) begin
         logic [K-1:0] a, s;
         a = la.pop_front();
         s = ls.pop_front();
         exp_d.push_back(sg ? s : a);
         exp_i.push_back(i);
      end
      pulse(sg);
      chk(busy, "busy_rise", busy, 1);
   endtask

   task automatic wait_done(input int mode, input int s0);
      int t = 0;
      while ((exp_d.size() != 0 || busy) && t < 3000) begin
         res_ready = mode == 1 ? (t % 4 == 0 || t % 4 == 3) : mode == 2 ? ($urandom_range(9) < 7) : 1'b1;
         starve_s = t >= s0 && t < s0 + 5;
         starve_a = mode == 2 && $urandom_range(9) == 0;
         tick();
         t++;
      end
      res_ready = 1;
      starve_s = 0;
      starve_a = 0;
      chk(t < 3000, "timeout", t, 3000);
   endtask

   initial begin
      int t, fv;
      logic [K-1:0] fd;
      logic [AW-1:0] fi;
      repeat (3) begin
         @(negedge clk);
         chk(!res_valid && !busy && !err_ovf, "reset_flags", {res_valid, busy, err_ovf}, 0);
         chk(!fifo_rd_en_a && res_data == 0 && res_idx == 0 && !res_last, "reset_out",
             {fifo_rd_en_a, res_last, res_idx, res_data}, 0);
      end
      tick();
      rst_n = 1;
      tick();
      // single op, sign=1, ready held high
      for (int i = 0; i < N; i++) load(K'(32'h100 + i), K'(32'h200 + i));
      res_ready = 1;
      start_op(1);
      t = 1;
      fv = 0;
      fd = '0;
      fi = '1;
      while (busy && t < 100) begin
         tick();
         t++;
         if (res_valid && fv == 0) begin
            fv = t;
            fd = res_data;
            fi = res_idx;
         end
      end
      chk(fv == 3, "first_latency", fv, 3);
      chk(fd == 256'h200, "first_word", fd, 256'h200);
      chk(fi == 0, "first_idx", fi, 0);
      chk(t == 20, "op_cycles", t, 20);
      chk(pops == 16, "pops_op1", pops, 16);
      chk(qa.size() == 0 && qs.size() == 0, "fifos_drained", qa.size() + qs.size(), 0);
      chk(exp_d.size() == 0, "all_words", exp_d.size(), 0);
      // sign=0, same data
      for (int i = 0; i < N; i++) load(K'(32'h100 + i), K'(32'h200 + i));
      start_op(0);
      wait_done(0, 9999);
      chk(pops == 32 && qs.size() == 0, "pops_op2", pops, 32);
      // backpressure 1,0,0,1
      for (int i = 0; i < N; i++) load(rnd(), rnd());
      start_op(1);
      wait_done(1, 9999);
      // sub FIFO starvation mid-op
      for (int i = 0; i < N; i++) load(rnd(), rnd());
      start_op(0);
      wait_done(0, 6);
      // randomized ops, some back-to-back
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N; i++) load(rnd(), rnd());
         start_op(1'($urandom_range(1)));
         if ($urandom_range(1) == 1) begin
            repeat ($urandom_range(1, 6)) tick();
            for (int i = 0; i < N; i++) load(rnd(), rnd());
            start_op(1'($urandom_range(1)));
         end
         wait_done(2, $urandom_range(3, 20));
      end
      // back-to-back plus overflow, then reset mid second op
      for (int i = 0; i < 2 * N; i++) load(rnd(), rnd());
      start_op(1);
      repeat (3) tick();
      start_op(0);
      tick();
      pulse(1);
      err_exp = 1;
      t = 0;
      while (exp_d.size() > N - 7 && t < 500) begin
         tick();
         t++;
      end
      chk(t < 500, "timeout_b2b", t, 500);
      rst_n = 0;
      #1;
      chk(!res_valid && !err_ovf && !busy, "reset_midop", {res_valid, err_ovf, busy}, 0);
      qa.delete();
      qs.delete();
      la.delete();
      ls.delete();
      exp_d.delete();
      exp_i.delete();
      err_exp = 0;
      stall = 0;
      ea = 1;
      es = 1;
      tick();
      pops = 0;
      xfers = 0;
      tick();
      rst_n = 1;
      tick();
      for (int i = 0; i < N; i++) load(rnd(), rnd());
      start_op(1'($urandom_range(1)));
      wait_done(2, 8);
      chk(pops == 16 && xfers == 16, "clean_after_reset", pops + xfers, 32);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/iddmm_result_rd.md
Name: iddmm_result_rd

Overview:
- Read-side companion of the Montgomery calculation core.
- The core writes each N-word result twice, into two FIFOs: the raw accumulator words and the accumulator-minus-modulus words. It then pulses done together with a select sign.
- This block drains both FIFOs in lockstep, keeps the words selected by the sign, discards the others, and presents the final N words LSW-first on a valid/ready stream.
- It sits between the two result FIFOs and the downstream consumer (exponentiation control / result RAM).

Parameters:
- K, 256, bits per word.
- N, 16, words per result.
- ADDR_W, $clog2(N), word index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cal_done  in  1  single-cycle pulse: one result fully written to both FIFOs
- cal_sign  in  1  sampled with cal_done; 1 = take sub FIFO word, 0 = take raw FIFO word
- fifo_empty_a  in  1  raw-result FIFO empty
- fifo_rd_en_a  out  1  raw-result FIFO pop
- fifo_rd_data_a  in  K  raw-result FIFO data, valid 1 cycle after pop
- fifo_empty_sub  in  1  subtracted-result FIFO empty
- fifo_rd_en_sub  out  1  subtracted-result FIFO pop
- fifo_rd_data_sub  in  K  subtracted-result FIFO data, valid 1 cycle after pop
- res_valid  out  1  output word valid
- res_ready  in  1  consumer accepts word
- res_data  out  K  selected word
- res_idx  out  ADDR_W  word index 0..N-1
- res_last  out  1  res_idx == N-1
- busy  out  1  an operation is active or pending
- err_ovf  out  1  sticky; cal_done arrived while a pending slot was already full

Behaviour:
- Reset (async): all outputs 0, state IDLE, counters 0, buffer empty, pending clear, err_ovf 0.
- FSM states:
  - IDLE: on cal_done, latch sign_cur = cal_sign, clear rd_cnt and out_cnt, go to DRAIN.
  - DRAIN: issue reads. When rd_cnt reaches N, go to FLUSH.
  - FLUSH: wait until out_cnt == N, i.e. the last word is accepted. Then:
    - if pending is set: load sign_cur from pending sign, clear pending, go to DRAIN;
    - otherwise go to IDLE.
- Pop rule:
  - fifo_rd_en_a and fifo_rd_en_sub are always asserted together.
  - Both assert only when all hold: state == DRAIN, !fifo_empty_a, !fifo_empty_sub, rd_cnt < N, and (buffer occupancy + in-flight reads) < 2.
  - FIFO read latency is 1 cycle. A registered rd_vld flag marks the cycle the data is captured.
- Capture:
  - When rd_vld is set, write (sign_cur ? fifo_rd_data_sub : fifo_rd_data_a) into a 2-entry output FIFO (skid buffer).
  - The unselected word is dropped.
- Output:
  - res_valid = buffer non-empty; res_data is the buffer head.
  - res_idx = out_cnt[ADDR_W-1:0].
  - Transfer happens on res_valid & res_ready; out_cnt increments on each transfer.
  - res_valid, res_data and res_idx hold stable while !res_ready.
- Throughput: with res_ready held high and FIFOs non-empty, one word per cycle. The first res_valid appears 2 cycles after the first pop (pop -> capture -> buffer head).
- cal_done while busy:
  - If pending is clear: set pending and store the sign.
  - If pending is already set: err_ovf <= 1 (sticky until reset). The new sign is ignored and the original pending sign is kept.
- cal_done in the same cycle as the FLUSH->IDLE transition: treated as an IDLE-start (go straight to DRAIN with the new sign); not counted as overflow.
- An empty FIFO mid-operation stalls pops with no word loss. Pops only ever occur in pairs, so the two FIFOs never desynchronise.
- busy = (state != IDLE) | pending.
- Reset asserted mid-operation: everything returns to reset values immediately. FIFO flushing is the system's responsibility.
- Width rules:
  - rd_cnt and out_cnt are ADDR_W+1 bits, so they reach N without wrapping.
  - res_idx wraps naturally from N-1 back to 0 for the next result.

Decomposition:
- Shared package iddmm_pkg: K, N, ADDR_W defaults; state enum {IDLE, DRAIN, FLUSH}.
- One sub-module: iddmm_skid_buf2 (2-entry K-bit valid/ready buffer with occupancy output), used for the output stage.

Test Plan:
- Single op, sign=1: both FIFOs preloaded with 16 words (raw = 0x100+i, sub = 0x200+i), cal_done pulse, res_ready=1 -> 16 transfers of 0x200..0x20F, res_idx 0..15, res_last on 0x20F, 16 pops per FIFO, both FIFOs empty at end, busy then falls.
- Single op, sign=0, same data -> outputs 0x100..0x10F; sub FIFO still fully drained.
- Backpressure: res_ready pattern 1,0,0,1 repeating -> no word lost or duplicated, data stable while stalled, never more than 2 outstanding captures.
- Starvation: fifo_empty_sub held high for 5 cycles mid-operation -> no pops during that window, then the sequence resumes in order.
- Back-to-back: second cal_done (sign=0) during DRAIN of first (sign=1) -> 16 sub words, then 16 raw words; err_ovf stays 0. A third cal_done before the second starts -> err_ovf=1.
- Reset at word 7 -> res_valid=0, err_ovf=0, busy=0 in the same cycle. After FIFO flush, a new op produces a clean sequence from idx 0.
